video_pat_sched: RTL and testbench

VIDEO_PAT_SCHED -- requirements
Module: video_pat_sched

---
 rtl/video_pat_sched_pkg.sv | 29 ++
 rtl/video_pat_hold_ctr.sv | 40 ++++
 rtl/video_pat_sched.sv | 156 +++++++++++++++
 tb/tb_video_pat_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pat_sched_pkg.sv
// Shared video definitions for the test-pattern scheduler: pattern codes,
// FSM state encodings and hold-counter operations.
package video_pat_sched_pkg;

   localparam logic [1:0] C_PAT_BLACK = 2'd0;
   localparam logic [1:0] C_PAT_CBAR  = 2'd1;
   localparam logic [1:0] C_PAT_RAMP  = 2'd2;
   localparam logic [1:0] C_PAT_FONT  = 2'd3;

   typedef enum logic [1:0] {
      S_AUTO  = 2'd0,
      S_PEND  = 2'd1,
      S_FORCE = 2'd2,
      S_REL   = 2'd3
   } sched_state_t;

   typedef enum logic [1:0] {
      HOLD_KEEP = 2'd0,
      HOLD_SAT  = 2'd1,
      HOLD_WRAP = 2'd2,
      HOLD_CLR  = 2'd3
   } hold_op_t;

   // Next pattern in the auto rotation over codes 0..npat-1.
   function automatic logic [1:0] next_pat(input logic [1:0] pat, input int npat);
      return (int'(pat) + 1 >= npat) ? C_PAT_BLACK : pat + 2'd1;
   endfunction

endpackage

// File: rtl/video_pat_hold_ctr.sv
// Field hold counter: counts fields shown in the current pattern, with
// saturating, wrapping (auto-advance) and clear operations.
module video_pat_hold_ctr
   import video_pat_sched_pkg::*;
#(
   parameter int C_HOLD_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       srst,
   input  hold_op_t   op,
   output logic [7:0] count,
   output logic       wrap
);

   localparam logic [7:0] C_LAST = 8'(C_HOLD_FRAMES - 1);

   // >= rather than == so a count left above the limit by manual hold still wraps.
   assign wrap = (count >= C_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (en) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         if (srst) begin
            count <= 8'd0;
         end else begin
            case (op)
               HOLD_SAT:  if (count != 8'hFF) count <= count + 8'd1;
               HOLD_WRAP: count <= wrap ? 8'd0 : count + 8'd1;
               HOLD_CLR:  count <= 8'd0;
               default:   count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/video_pat_sched.sv
// Test-pattern scheduler: auto-cycles patterns per field and accepts host
// force requests via a 4-phase handshake. Define VIDEO_PAT_SCHED_BLANK_EN to
// insert one black field before every change to a non-zero pattern.
module video_pat_sched
   import video_pat_sched_pkg::*;
#(
   parameter int C_HOLD_FRAMES = 60,
   parameter int C_NPAT        = 4
) (
   input  logic       CK_i,
   input  logic       XARST_i,
   input  logic       CK_EE_i,
   input  logic       RST_i,
   input  logic       VSTART_i,
   input  logic       AUTO_i,
   input  logic       REQ_i,
   input  logic [1:0] REQ_PATs_i,
   output logic       ACK_o,
   output logic [1:0] PATs_o,
   output logic       PAT_CHG_o,
   output logic [7:0] HOLD_CTRs_o
);

`ifdef VIDEO_PAT_SCHED_BLANK_EN
   localparam bit C_BLANK_EN = 1'b1;
`else
   localparam bit C_BLANK_EN = 1'b0;
`endif

   sched_state_t state;
   logic [1:0]   pat;
   logic [1:0]   req_pat;
   logic [1:0]   blank_pat;
   logic         blank_act;
   logic         ack;
   logic         chg;
   logic         hold_wrap;
   logic [1:0]   auto_tgt;
   hold_op_t     hold_op;

   assign auto_tgt = next_pat(pat, C_NPAT);

   // NOTE: combinational decode starts from a default so no latch is inferred.
   always_comb begin
      hold_op = HOLD_KEEP;
      if (VSTART_i) begin
         case (state)
            S_AUTO: begin
               if (REQ_i && !ack) hold_op = HOLD_SAT;
               else if (blank_act) hold_op = HOLD_CLR;
               else if (AUTO_i)    hold_op = HOLD_WRAP;
               else                hold_op = HOLD_SAT;
            end
            S_PEND:  hold_op = HOLD_CLR;
            S_FORCE: hold_op = HOLD_SAT;
            S_REL:   hold_op = (!REQ_i && AUTO_i) ? HOLD_CLR : HOLD_SAT;
            default: hold_op = HOLD_KEEP;
         endcase
      end
   end

   video_pat_hold_ctr #(
      .C_HOLD_FRAMES(C_HOLD_FRAMES)
   ) u_hold_ctr (
      .clk  (CK_i),
      .rst_n(XARST_i),
      .en   (CK_EE_i),
      .srst (RST_i),
      .op   (hold_op),
      .count(HOLD_CTRs_o),
      .wrap (hold_wrap)
   );

   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         state     <= S_AUTO;
         pat       <= C_PAT_BLACK;
         req_pat   <= C_PAT_BLACK;
         blank_pat <= C_PAT_BLACK;
         blank_act <= 1'b0;
         ack       <= 1'b0;
         chg       <= 1'b0;
      end else if (CK_EE_i) begin
         chg <= 1'b0;
         if (RST_i) begin
            state     <= S_AUTO;
            pat       <= C_PAT_BLACK;
            blank_act <= 1'b0;
            ack       <= 1'b0;
         end else begin
            case (state)
               S_AUTO: begin
                  // A new request overrides both auto-advance and an auto blank in flight.
                  if (REQ_i && !ack) begin
                     req_pat   <= REQ_PATs_i;
                     blank_act <= 1'b0;
                     state     <= S_PEND;
                  end else if (VSTART_i) begin
                     if (blank_act) begin
                        pat       <= blank_pat;
                        chg       <= (blank_pat != pat);
                        blank_act <= 1'b0;
                     end else if (AUTO_i && hold_wrap) begin
                        if (C_BLANK_EN && auto_tgt != C_PAT_BLACK) begin
                           pat       <= C_PAT_BLACK;
                           chg       <= (pat != C_PAT_BLACK);
                           blank_act <= 1'b1;
                           blank_pat <= auto_tgt;
                        end else begin
                           pat <= auto_tgt;
                           chg <= (auto_tgt != pat);
                        end
                     end
                  end
               end
               S_PEND: begin
                  if (VSTART_i) begin
                     if (C_BLANK_EN && !blank_act && req_pat != C_PAT_BLACK && req_pat != pat) begin
                        pat       <= C_PAT_BLACK;
                        chg       <= (pat != C_PAT_BLACK);
                        blank_act <= 1'b1;
                     end else begin
                        pat       <= req_pat;
                        chg       <= (req_pat != pat);
                        blank_act <= 1'b0;
                        state     <= S_FORCE;
                     end
                  end
               end
               S_FORCE: begin
                  if (!ack) begin
                     ack <= 1'b1;
                  end else if (!REQ_i) begin
                     ack   <= 1'b0;
                     state <= S_REL;
                  end
               end
               S_REL: begin
                  if (REQ_i) begin
                     req_pat <= REQ_PATs_i;
                     state   <= S_PEND;
                  end else if (AUTO_i && VSTART_i) begin
                     state <= S_AUTO;
                  end
               end
               default: state <= S_AUTO;
            endcase
         end
      end
   end

   assign ACK_o     = ack;
   assign PATs_o    = pat;
   assign PAT_CHG_o = chg;

endmodule

// File: tb/tb_video_pat_sched.sv
// Directed bench for video_pat_sched (C_HOLD_FRAMES=3, C_NPAT=4); the blank
// insertion expectations follow VIDEO_PAT_SCHED_BLANK_EN when it is defined.
module tb_video_pat_sched;

   logic       CK_i = 1'b0;
   logic       XARST_i = 1'b0;
   logic       CK_EE_i = 1'b1;
   logic       RST_i = 1'b0;
   logic       VSTART_i = 1'b0;
   logic       AUTO_i = 1'b0;
   logic       REQ_i = 1'b0;
   logic [1:0] REQ_PATs_i = 2'd0;
   logic       ACK_o;
   logic [1:0] PATs_o;
   logic       PAT_CHG_o;
   logic [7:0] HOLD_CTRs_o;

   int total = 0;
   int bad = 0;
   int chg_cnt = 0;

   video_pat_sched #(
      .C_HOLD_FRAMES(3),
      .C_NPAT(4)
   ) dut (
      .CK_i       (CK_i),
      .XARST_i    (XARST_i),
      .CK_EE_i    (CK_EE_i),
      .RST_i      (RST_i),
      .VSTART_i   (VSTART_i),
      .AUTO_i     (AUTO_i),
      .REQ_i      (REQ_i),
      .REQ_PATs_i (REQ_PATs_i),
      .ACK_o      (ACK_o),
      .PATs_o     (PATs_o),
      .PAT_CHG_o  (PAT_CHG_o),
      .HOLD_CTRs_o(HOLD_CTRs_o)
   );

   always #40 CK_i = ~CK_i;

   always @(negedge CK_i) if (PAT_CHG_o === 1'b1) chg_cnt++;

   task automatic tick();
      @(negedge CK_i);
   endtask

   task automatic vs_pulse();
      VSTART_i = 1'b1;
      @(negedge CK_i);
      VSTART_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL reset_pat: got %0d want 0", PATs_o); end
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got %0b want 0", ACK_o); end
      total++; if (PAT_CHG_o !== 1'b0) begin bad++; $display("FAIL reset_chg: got %0b want 0", PAT_CHG_o); end
      total++; if (HOLD_CTRs_o !== 8'd0) begin bad++; $display("FAIL reset_hold: got %0d want 0", HOLD_CTRs_o); end
      #10 XARST_i = 1'b1;
      tick();
   endtask

   task automatic test_auto_run();
      int base;
      logic [1:0] exp_pat;
      AUTO_i = 1'b1;
      tick();
      base = chg_cnt;
      for (int i = 1; i <= 13; i++) begin
         vs_pulse();
         exp_pat = 2'((i / 3) % 4);
         total++; if (PATs_o !== exp_pat) begin bad++; $display("FAIL auto_pat[%0d]: got %0d want %0d", i, PATs_o, exp_pat); end
         total++; if (HOLD_CTRs_o !== 8'(i % 3)) begin bad++; $display("FAIL auto_hold[%0d]: got %0d want %0d", i, HOLD_CTRs_o, i % 3); end
         total++; if (PAT_CHG_o !== (i % 3 == 0)) begin bad++; $display("FAIL auto_chg[%0d]: got %0b want %0b", i, PAT_CHG_o, (i % 3 == 0)); end
         tick();
      end
      total++; if (chg_cnt - base !== 4) begin bad++; $display("FAIL auto_chg_count: got %0d want 4", chg_cnt - base); end
   endtask

   task automatic test_clk_en();
      CK_EE_i = 1'b0;
      VSTART_i = 1'b1;
      repeat (2) tick();
      VSTART_i = 1'b0;
      total++; if (HOLD_CTRs_o !== 8'd1) begin bad++; $display("FAIL ce_hold: got %0d want 1", HOLD_CTRs_o); end
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL ce_pat: got %0d want 0", PATs_o); end
      CK_EE_i = 1'b1;
      tick();
   endtask

   task automatic test_force();
      REQ_PATs_i = 2'd2;
      REQ_i = 1'b1;
      tick();
      REQ_PATs_i = 2'd1;
      repeat (2) tick();
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL force_midfield_pat: got %0d want 0", PATs_o); end
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL force_midfield_ack: got %0b want 0", ACK_o); end
      vs_pulse();
      total++; if (PATs_o !== 2'd2) begin bad++; $display("FAIL force_pat: got %0d want 2", PATs_o); end
      total++; if (PAT_CHG_o !== 1'b1) begin bad++; $display("FAIL force_chg: got %0b want 1", PAT_CHG_o); end
      total++; if (HOLD_CTRs_o !== 8'd0) begin bad++; $display("FAIL force_hold_clr: got %0d want 0", HOLD_CTRs_o); end
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL force_ack_early: got %0b want 0", ACK_o); end
      tick();
      total++; if (ACK_o !== 1'b1) begin bad++; $display("FAIL force_ack: got %0b want 1", ACK_o); end
      total++; if (PAT_CHG_o !== 1'b0) begin bad++; $display("FAIL force_chg_pulse: got %0b want 0", PAT_CHG_o); end
      repeat (3) begin vs_pulse(); tick(); end
      total++; if (HOLD_CTRs_o !== 8'd3) begin bad++; $display("FAIL force_hold_count: got %0d want 3", HOLD_CTRs_o); end
      total++; if (PATs_o !== 2'd2) begin bad++; $display("FAIL force_no_auto: got %0d want 2", PATs_o); end
      REQ_i = 1'b0;
      tick();
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL force_ack_drop: got %0b want 0", ACK_o); end
   endtask

   task automatic test_return_auto();
      tick();
      vs_pulse();
      total++; if (HOLD_CTRs_o !== 8'd0) begin bad++; $display("FAIL ret_hold: got %0d want 0", HOLD_CTRs_o); end
      total++; if (PATs_o !== 2'd2) begin bad++; $display("FAIL ret_pat: got %0d want 2", PATs_o); end
      tick();
      repeat (2) begin vs_pulse(); tick(); end
      total++; if (HOLD_CTRs_o !== 8'd2) begin bad++; $display("FAIL ret_hold2: got %0d want 2", HOLD_CTRs_o); end
      total++; if (PATs_o !== 2'd2) begin bad++; $display("FAIL ret_pat_hold: got %0d want 2", PATs_o); end
      vs_pulse();
      total++; if (PATs_o !== 2'd3) begin bad++; $display("FAIL ret_advance: got %0d want 3", PATs_o); end
      total++; if (HOLD_CTRs_o !== 8'd0) begin bad++; $display("FAIL ret_hold_wrap: got %0d want 0", HOLD_CTRs_o); end
      tick();
   endtask

   task automatic test_coincidence();
      repeat (2) begin vs_pulse(); tick(); end
      REQ_PATs_i = 2'd1;
      REQ_i = 1'b1;
      VSTART_i = 1'b1;
      tick();
      VSTART_i = 1'b0;
      total++; if (PATs_o !== 2'd3) begin bad++; $display("FAIL coin_no_advance: got %0d want 3", PATs_o); end
      total++; if (PAT_CHG_o !== 1'b0) begin bad++; $display("FAIL coin_no_chg: got %0b want 0", PAT_CHG_o); end
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL coin_ack: got %0b want 0", ACK_o); end
      tick();
      vs_pulse();
      total++; if (PATs_o !== 2'd1) begin bad++; $display("FAIL coin_pat: got %0d want 1", PATs_o); end
      total++; if (HOLD_CTRs_o !== 8'd0) begin bad++; $display("FAIL coin_hold: got %0d want 0", HOLD_CTRs_o); end
      tick();
      total++; if (ACK_o !== 1'b1) begin bad++; $display("FAIL coin_ack_set: got %0b want 1", ACK_o); end
      REQ_i = 1'b0;
      tick();
   endtask

   task automatic test_same_pattern();
      int base;
      REQ_PATs_i = 2'd1;
      REQ_i = 1'b1;
      tick();
      base = chg_cnt;
      vs_pulse();
      total++; if (PATs_o !== 2'd1) begin bad++; $display("FAIL same_pat: got %0d want 1", PATs_o); end
      tick();
      total++; if (ACK_o !== 1'b1) begin bad++; $display("FAIL same_ack: got %0b want 1", ACK_o); end
      REQ_i = 1'b0;
      tick();
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL same_ack_drop: got %0b want 0", ACK_o); end
      total++; if (chg_cnt - base !== 0) begin bad++; $display("FAIL same_chg_count: got %0d want 0", chg_cnt - base); end
   endtask

   task automatic test_force_1_to_2();
      int base;
      REQ_PATs_i = 2'd2;
      REQ_i = 1'b1;
      tick();
      base = chg_cnt;
      vs_pulse();
`ifdef VIDEO_PAT_SCHED_BLANK_EN
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL f12_blank_pat: got %0d want 0", PATs_o); end
      tick();
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL f12_ack_wait: got %0b want 0", ACK_o); end
      vs_pulse();
      total++; if (PATs_o !== 2'd2) begin bad++; $display("FAIL f12_pat: got %0d want 2", PATs_o); end
      tick();
      total++; if (ACK_o !== 1'b1) begin bad++; $display("FAIL f12_ack: got %0b want 1", ACK_o); end
      total++; if (chg_cnt - base !== 2) begin bad++; $display("FAIL f12_chg_count: got %0d want 2", chg_cnt - base); end
`else
      total++; if (PATs_o !== 2'd2) begin bad++; $display("FAIL f12_pat: got %0d want 2", PATs_o); end
      tick();
      total++; if (ACK_o !== 1'b1) begin bad++; $display("FAIL f12_ack: got %0b want 1", ACK_o); end
      total++; if (chg_cnt - base !== 1) begin bad++; $display("FAIL f12_chg_count: got %0d want 1", chg_cnt - base); end
`endif
      REQ_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_request();
      AUTO_i = 1'b0;
      REQ_PATs_i = 2'd3;
      REQ_i = 1'b1;
      tick();
      REQ_i = 1'b0;
      XARST_i = 1'b0;
      #5;
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL rst_pend_pat: got %0d want 0", PATs_o); end
      total++; if (HOLD_CTRs_o !== 8'd0) begin bad++; $display("FAIL rst_pend_hold: got %0d want 0", HOLD_CTRs_o); end
      #5 XARST_i = 1'b1;
      tick();
      repeat (2) begin vs_pulse(); tick(); end
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL rst_discard_pat: got %0d want 0", PATs_o); end
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL rst_discard_ack: got %0b want 0", ACK_o); end
      REQ_i = 1'b1;
      tick();
      XARST_i = 1'b0;
      #5;
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL rst_held_ack: got %0b want 0", ACK_o); end
      #5 XARST_i = 1'b1;
      tick();
      vs_pulse();
`ifdef VIDEO_PAT_SCHED_BLANK_EN
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL f03_blank_pat: got %0d want 0", PATs_o); end
      total++; if (PAT_CHG_o !== 1'b0) begin bad++; $display("FAIL f03_blank_chg: got %0b want 0", PAT_CHG_o); end
      tick();
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL f03_ack_wait: got %0b want 0", ACK_o); end
      vs_pulse();
`endif
      total++; if (PATs_o !== 2'd3) begin bad++; $display("FAIL rst_reaccept_pat: got %0d want 3", PATs_o); end
      total++; if (PAT_CHG_o !== 1'b1) begin bad++; $display("FAIL rst_reaccept_chg: got %0b want 1", PAT_CHG_o); end
      tick();
      total++; if (ACK_o !== 1'b1) begin bad++; $display("FAIL rst_reaccept_ack: got %0b want 1", ACK_o); end
      REQ_i = 1'b0;
      tick();
   endtask

   task automatic test_sync_reset();
      vs_pulse();
      tick();
      total++; if (HOLD_CTRs_o !== 8'd1) begin bad++; $display("FAIL srst_pre_hold: got %0d want 1", HOLD_CTRs_o); end
      CK_EE_i = 1'b0;
      RST_i = 1'b1;
      repeat (2) tick();
      total++; if (PATs_o !== 2'd3) begin bad++; $display("FAIL srst_ce_low: got %0d want 3", PATs_o); end
      CK_EE_i = 1'b1;
      tick();
      RST_i = 1'b0;
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL srst_pat: got %0d want 0", PATs_o); end
      total++; if (HOLD_CTRs_o !== 8'd0) begin bad++; $display("FAIL srst_hold: got %0d want 0", HOLD_CTRs_o); end
      total++; if (ACK_o !== 1'b0) begin bad++; $display("FAIL srst_ack: got %0b want 0", ACK_o); end
      tick();
   endtask

   task automatic test_saturate();
      AUTO_i = 1'b0;
      repeat (300) vs_pulse();
      tick();
      total++; if (HOLD_CTRs_o !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", HOLD_CTRs_o); end
      total++; if (PATs_o !== 2'd0) begin bad++; $display("FAIL sat_pat: got %0d want 0", PATs_o); end
   endtask

   initial begin
      test_reset();
      test_auto_run();
      test_clk_en();
      test_force();
      test_return_auto();
      test_coincidence();
      test_same_pattern();
      test_force_1_to_2();
      test_reset_mid_request();
      test_sync_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
